axis_spi_sched: RTL and testbench
=================================

# axis_spi_sched

Round-robin scheduler that shares one AXI-Stream-fed SPI transmitter between up to four command sources (e.g. PS register writes, DAC/LO init sequencer, AGC loop). It accepts one 32-bit word from the winning source, issues it to the SPI master, tracks the master's `busy` through the whole frame, and enforces a minimum CS-high gap before the next grant. It also publishes a one-hot source select that drives the downstream CS/device routing mux.

## Interface
- `NUM_SRC`, 2 — number of requesters, legal 2..4.
- `GAP_CYCLES`, 8 — idle clocks inserted after `busy` falls, 0..255; 0 means no gap.
- `WDOG_CYCLES`, 4 — clocks allowed for `spi_busy` to rise after issue, 1..15.

- `clk` in 1 — single clock for all logic.
- `resetn` in 1 — asynchronous, active-low reset.
- `s_axis_tdata` in NUM_SRC*32 — packed source words; source i is at [32*i+31:32*i].
- `s_axis_tvalid` in NUM_SRC — per-source valid.
- `s_axis_tready` out NUM_SRC — per-source ready; at most one bit high.
- `m_axis_tdata` out 32 — word to the SPI master.
- `m_axis_tvalid` out 1 — word valid.
- `m_axis_tready` in 1 — SPI master ready.
- `spi_busy` in 1 — SPI master busy flag.
- `src_sel` out NUM_SRC — one-hot owner of the current frame; 0 when no frame is active.
- `active` out 1 — high from capture through the end of GAP.
- `frame_cnt` out 16 — count of completed frames; wraps at 0xFFFF to 0.
- `wdog_err` out 1 — sticky; set when `spi_busy` fails to rise. Cleared only by reset.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
- **IDLE**
  - The winner is the first source with tvalid set, searching from `last+1` modulo NUM_SRC.
  - `s_axis_tready` is driven combinationally, for the winner only.
  - On the handshake: capture the data into the hold register, set `src_sel`/`last` to the winner, and go to ISSUE.
  - With no requests, stay in IDLE; all tready bits are 0.
- **ISSUE**
  - `m_axis_tvalid`=1 with the held data.
  - On `m_axis_tready`: go to WAIT_BUSY and load the watchdog counter with 0.
  - tvalid and data stay stable while stalled.
- **WAIT_BUSY**
  - If `spi_busy`=1, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches WDOG_CYCLES: set `wdog_err` and go to GAP. The frame is not counted.
- **WAIT_DONE**
  - On `spi_busy`=0: increment `frame_cnt` and go to GAP (or IDLE if GAP_CYCLES=0).
- **GAP**
  - Count GAP_CYCLES clocks, then go to IDLE.
  - `src_sel` clears on entry to IDLE.
- Arbitration is fully fair. A source that holds tvalid continuously gets every NUM_SRC-th grant when all sources request.
- Source tvalid dropping without a handshake is legal; the arbiter re-evaluates every IDLE cycle.
- `s_axis_tdata` of non-winners is ignored.

## Timing
- **Reset values:**
  - State: IDLE.
  - `last` = NUM_SRC-1, so source 0 wins first.
  - Hold data: 0.
  - Outputs: `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `src_sel`=0, `active`=0, `frame_cnt`=0, `wdog_err`=0.
  - Reset asserted mid-frame returns to IDLE immediately. The downstream master is reset by the same `resetn`.
- **Latencies:**
  - Source handshake to `m_axis_tvalid`: 1 clock.
  - `spi_busy` fall to GAP entry: 1 clock.
  - GAP lasts exactly GAP_CYCLES clocks.
  - Last GAP clock to next possible source handshake: 1 clock (the IDLE cycle).
- **Simultaneous events:**
  - `m_axis_tready` and `spi_busy`=1 in the same ISSUE cycle: go to WAIT_BUSY. Busy is then seen the next cycle; no special case.
  - `spi_busy` already 0 on WAIT_DONE entry: frame completes that cycle.
- **Sizing and bounds:**
  - The GAP counter is 8 bits and the watchdog counter is 4 bits.
  - `src_sel` and `active` never change between capture and GAP exit.

## Structure
- Package `spi_sched_pkg`:
  - state enumeration (3-bit encoding);
  - `WORD_W`=32;
  - `FRAME_CNT_W`=16;
  - maximum NUM_SRC=4.
- Sub-module `spi_sched_rr_pick`: combinational round-robin priority search. It takes (req vector, last index) and returns (grant one-hot, grant index, any).
- Counters, FSM, hold register and outputs live in the top module.

## Test plan
- **Single source.** NUM_SRC=2. Source 0 sends 0xA5A5_0001 with the SPI master model holding busy for 40 clocks.
  - `m_axis_tdata`=0xA5A5_0001 one clock after the handshake.
  - `src_sel`=01 until 8 clocks after busy falls.
  - `frame_cnt`=1.
- **Round robin.** NUM_SRC=3, all sources valid continuously.
  - Grant order is 0,1,2,0,1,2.
  - Each source's tready pulses exactly once per frame.
- **Stall.** `m_axis_tready` held low 10 clocks in ISSUE.
  - tvalid and data stay stable.
  - No source tready asserts during the stall.
- **Watchdog.** The master accepts the word but never raises busy.
  - `wdog_err`=1 after 4 clocks.
  - `frame_cnt` is unchanged.
  - The next request is served normally.
- **Zero gap.** GAP_CYCLES=0 and back-to-back requests: the next source handshake occurs 1 clock after busy falls.
- **Reset mid-frame.** Assert `resetn` low during WAIT_DONE.
  - All outputs take their reset values asynchronously.
  - After release, source 0 wins first.

Source files
------------

// File: rtl/spi_sched_pkg.sv
// Shared types and sizing constants for the AXI-Stream SPI scheduler.
// Imported by the round-robin picker and the top-level scheduler.
package spi_sched_pkg;

    localparam int WORD_W      = 32;
    localparam int FRAME_CNT_W = 16;
    localparam int MAX_SRC     = 4;
    localparam int IDX_W       = 2;
    localparam int GAP_CNT_W   = 8;
    localparam int WDOG_CNT_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } state_t;

endpackage

// File: rtl/spi_sched_rr_pick.sv
// Combinational round-robin search: first requester after 'last', wrapping
// modulo NUM_SRC, so the most recent owner has the lowest priority.
module spi_sched_rr_pick
    import spi_sched_pkg::*;
#(
    parameter int NUM_SRC = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(last) + k) % NUM_SRC;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/axis_spi_sched.sv
// Shares one SPI transmitter between NUM_SRC AXI-Stream command sources:
// round-robin grant, issue, busy tracking with watchdog, and CS-high gap.
module axis_spi_sched
    import spi_sched_pkg::*;
#(
    parameter int NUM_SRC     = 2,
    parameter int GAP_CYCLES  = 8,
    parameter int WDOG_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_SRC*WORD_W-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]        s_axis_tvalid,
    output logic [NUM_SRC-1:0]        s_axis_tready,
    output logic [WORD_W-1:0]         m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    input  logic                      spi_busy,
    output logic [NUM_SRC-1:0]        src_sel,
    output logic                      active,
    output logic [FRAME_CNT_W-1:0]    frame_cnt,
    output logic                      wdog_err
);

    localparam bit                    HAS_GAP    = (GAP_CYCLES > 0);
    localparam logic [GAP_CNT_W-1:0]  GAP_LAST   = HAS_GAP ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic [WDOG_CNT_W-1:0] WDOG_LIMIT = WDOG_CNT_W'(WDOG_CYCLES);

    state_t                state;
    logic [IDX_W-1:0]      last;
    logic [WORD_W-1:0]     hold_data;
    logic [GAP_CNT_W-1:0]  gap_cnt;
    logic [WDOG_CNT_W-1:0] wdog_cnt;
    logic [NUM_SRC-1:0]    grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  any;
    logic [WORD_W-1:0]     win_data;

    spi_sched_rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .req       (s_axis_tvalid),
        .last      (last),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    assign win_data      = s_axis_tdata[int'(grant_idx)*WORD_W +: WORD_W];
    assign s_axis_tready = (state == S_IDLE) ? grant : '0;
    assign m_axis_tdata  = hold_data;

    // src_sel and active are held from capture until the frame fully ends
    // (after GAP), since they steer the downstream CS routing mux.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            last          <= IDX_W'(NUM_SRC - 1);
            hold_data     <= '0;
            m_axis_tvalid <= 1'b0;
            src_sel       <= '0;
            active        <= 1'b0;
            frame_cnt     <= '0;
            wdog_err      <= 1'b0;
            gap_cnt       <= '0;
            wdog_cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any) begin
                        hold_data     <= win_data;
                        m_axis_tvalid <= 1'b1;
                        src_sel       <= grant;
                        last          <= grant_idx;
                        active        <= 1'b1;
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        wdog_cnt      <= '0;
                        state         <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (spi_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (wdog_cnt + 1'b1 == WDOG_LIMIT) begin
                        wdog_err <= 1'b1;
                        if (HAS_GAP) begin
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end else begin
                            src_sel <= '0;
                            active  <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end else begin
                        wdog_cnt <= wdog_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!spi_busy) begin
                        frame_cnt <= frame_cnt + 1'b1;
                        if (HAS_GAP) begin
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end else begin
                            src_sel <= '0;
                            active  <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        src_sel <= '0;
                        active  <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_spi_sched.sv
// Directed bench for axis_spi_sched: a 3-source/8-gap instance driven from a
// vector table plus hand sequences, and a 2-source zero-gap instance.
module tb_axis_spi_sched;

    logic        clk = 1'b0;
    logic        resetn;

    logic [95:0] s_tdata;
    logic [2:0]  s_tvalid;
    logic [2:0]  s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        busy;
    logic [2:0]  src_sel;
    logic        active;
    logic [15:0] frame_cnt;
    logic        wdog_err;

    logic [63:0] z_tdata;
    logic [1:0]  z_tvalid;
    logic [1:0]  z_tready;
    logic [31:0] z_m_tdata;
    logic        z_m_tvalid;
    logic        z_m_tready;
    logic        z_busy;
    logic [1:0]  z_src_sel;
    logic        z_active;
    logic [15:0] z_frame_cnt;
    logic        z_wdog_err;

    int check_count = 0;
    int pass_count  = 0;

    typedef struct {
        logic [2:0]  valid;
        logic [95:0] data;
        logic [2:0]  exp_grant;
        logic [31:0] exp_data;
        logic [15:0] exp_cnt;
        int          busy_len;
        int          stall;
    } vec_t;

    vec_t vecs[11];
    vec_t w;

    always #5 clk = ~clk;

    axis_spi_sched #(
        .NUM_SRC     (3),
        .GAP_CYCLES  (8),
        .WDOG_CYCLES (4)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .spi_busy      (busy),
        .src_sel       (src_sel),
        .active        (active),
        .frame_cnt     (frame_cnt),
        .wdog_err      (wdog_err)
    );

    axis_spi_sched #(
        .NUM_SRC     (2),
        .GAP_CYCLES  (0),
        .WDOG_CYCLES (4)
    ) dut_z (
        .clk           (clk),
        .resetn        (resetn),
        .s_axis_tdata  (z_tdata),
        .s_axis_tvalid (z_tvalid),
        .s_axis_tready (z_tready),
        .m_axis_tdata  (z_m_tdata),
        .m_axis_tvalid (z_m_tvalid),
        .m_axis_tready (z_m_tready),
        .spi_busy      (z_busy),
        .src_sel       (z_src_sel),
        .active        (z_active),
        .frame_cnt     (z_frame_cnt),
        .wdog_err      (z_wdog_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic [2:0] valid, input logic [95:0] data);
        s_tvalid = valid;
        s_tdata  = data;
    endtask

    // One complete frame on the 3-source instance, starting and ending on a
    // negedge; the next call's first negedge is the first IDLE cycle.
    task automatic runFrame(input vec_t v);
        @(negedge clk);
        applyStimulus(v.valid, v.data);
        #1;
        checkOutput("idle_src_sel", 32'(src_sel), 32'd0);
        checkOutput("idle_active", 32'(active), 32'd0);
        checkOutput("grant_tready", 32'(s_tready), 32'(v.exp_grant));
        @(negedge clk);
        applyStimulus(v.valid & ~v.exp_grant, v.data);
        #1;
        checkOutput("issue_tvalid", 32'(m_tvalid), 32'd1);
        checkOutput("issue_tdata", m_tdata, v.exp_data);
        checkOutput("issue_src_sel", 32'(src_sel), 32'(v.exp_grant));
        checkOutput("issue_active", 32'(active), 32'd1);
        checkOutput("issue_tready_low", 32'(s_tready), 32'd0);
        for (int i = 0; i < v.stall; i++) begin
            @(negedge clk);
            applyStimulus(3'b111, ~v.data);
            #1;
            checkOutput("stall_tvalid", 32'(m_tvalid), 32'd1);
            checkOutput("stall_tdata", m_tdata, v.exp_data);
            checkOutput("stall_tready_low", 32'(s_tready), 32'd0);
        end
        m_tready = 1'b1;
        @(negedge clk);
        m_tready = 1'b0;
        busy     = 1'b1;
        applyStimulus(v.valid & ~v.exp_grant, v.data);
        #1;
        checkOutput("wait_tvalid_low", 32'(m_tvalid), 32'd0);
        repeat (v.busy_len) @(negedge clk);
        #1;
        checkOutput("busy_cnt_hold", 32'(frame_cnt), 32'(v.exp_cnt - 16'd1));
        busy = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("done_frame_cnt", 32'(frame_cnt), 32'(v.exp_cnt));
        checkOutput("gap_src_sel", 32'(src_sel), 32'(v.exp_grant));
        checkOutput("gap_active", 32'(active), 32'd1);
        repeat (7) @(negedge clk);
        #1;
        checkOutput("gap_end_src_sel", 32'(src_sel), 32'(v.exp_grant));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vecs[0]  = '{3'b001, {32'h2222_0001, 32'h1111_0001, 32'hA5A5_0001}, 3'b001, 32'hA5A5_0001, 16'd1, 40, 0};
        vecs[1]  = '{3'b111, {32'h2222_0002, 32'h1111_0002, 32'h0000_0002}, 3'b010, 32'h1111_0002, 16'd2, 3, 0};
        vecs[2]  = '{3'b111, {32'h2222_0003, 32'h1111_0003, 32'h0000_0003}, 3'b100, 32'h2222_0003, 16'd3, 3, 0};
        vecs[3]  = '{3'b111, {32'h2222_0004, 32'h1111_0004, 32'h0000_0004}, 3'b001, 32'h0000_0004, 16'd4, 3, 0};
        vecs[4]  = '{3'b111, {32'h2222_0005, 32'h1111_0005, 32'h0000_0005}, 3'b010, 32'h1111_0005, 16'd5, 2, 0};
        vecs[5]  = '{3'b111, {32'h2222_0006, 32'h1111_0006, 32'h0000_0006}, 3'b100, 32'h2222_0006, 16'd6, 2, 0};
        vecs[6]  = '{3'b101, {32'h2222_0007, 32'h1111_0007, 32'h0000_0007}, 3'b001, 32'h0000_0007, 16'd7, 1, 0};
        vecs[7]  = '{3'b101, {32'h2222_0008, 32'h1111_0008, 32'h0000_0008}, 3'b100, 32'h2222_0008, 16'd8, 1, 0};
        vecs[8]  = '{3'b010, {32'h2222_0009, 32'h1111_0009, 32'h0000_0009}, 3'b010, 32'h1111_0009, 16'd9, 4, 0};
        vecs[9]  = '{3'b011, {32'h2222_000A, 32'h1111_000A, 32'h0000_000A}, 3'b001, 32'h0000_000A, 16'd10, 4, 0};
        vecs[10] = '{3'b001, {32'h2222_000B, 32'h1111_000B, 32'h0000_000B}, 3'b001, 32'h0000_000B, 16'd11, 3, 10};

        resetn     = 1'b0;
        applyStimulus(3'b000, 96'd0);
        m_tready   = 1'b0;
        busy       = 1'b0;
        z_tvalid   = 2'b00;
        z_tdata    = 64'd0;
        z_m_tready = 1'b0;
        z_busy     = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_tready", 32'(s_tready), 32'd0);
        checkOutput("rst_tvalid", 32'(m_tvalid), 32'd0);
        checkOutput("rst_tdata", m_tdata, 32'd0);
        checkOutput("rst_src_sel", 32'(src_sel), 32'd0);
        checkOutput("rst_active", 32'(active), 32'd0);
        checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("rst_wdog_err", 32'(wdog_err), 32'd0);
        checkOutput("rst_z_tvalid", 32'(z_m_tvalid), 32'd0);
        checkOutput("rst_z_frame_cnt", 32'(z_frame_cnt), 32'd0);
        resetn = 1'b1;

        // Zero-gap instance: next handshake lands in the cycle right after busy falls.
        @(negedge clk);
        z_tvalid = 2'b11;
        z_tdata  = {32'hBBBB_0002, 32'hAAAA_0001};
        #1;
        checkOutput("z_grant0", 32'(z_tready), 32'd1);
        @(negedge clk);
        #1;
        checkOutput("z_issue_tdata0", z_m_tdata, 32'hAAAA_0001);
        checkOutput("z_issue_tvalid0", 32'(z_m_tvalid), 32'd1);
        checkOutput("z_issue_tready_low", 32'(z_tready), 32'd0);
        z_m_tready = 1'b1;
        @(negedge clk);
        z_m_tready = 1'b0;
        z_busy     = 1'b1;
        repeat (3) @(negedge clk);
        z_busy = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("z_frame_cnt1", 32'(z_frame_cnt), 32'd1);
        checkOutput("z_idle_src_sel", 32'(z_src_sel), 32'd0);
        checkOutput("z_idle_active", 32'(z_active), 32'd0);
        checkOutput("z_grant1", 32'(z_tready), 32'd2);
        @(negedge clk);
        #1;
        checkOutput("z_issue_tdata1", z_m_tdata, 32'hBBBB_0002);
        checkOutput("z_issue_src_sel1", 32'(z_src_sel), 32'd2);
        z_m_tready = 1'b1;
        @(negedge clk);
        z_m_tready = 1'b0;
        z_busy     = 1'b1;
        z_tvalid   = 2'b00;
        @(negedge clk);
        z_busy = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("z_frame_cnt2", 32'(z_frame_cnt), 32'd2);
        checkOutput("z_end_active", 32'(z_active), 32'd0);

        for (int i = 0; i < 11; i++) begin
            runFrame(vecs[i]);
        end

        // Watchdog: source 1 wins, the master accepts but never raises busy.
        @(negedge clk);
        applyStimulus(3'b010, {32'h2222_00EE, 32'h1111_00EE, 32'h0000_00EE});
        #1;
        checkOutput("wd_grant", 32'(s_tready), 32'd2);
        @(negedge clk);
        applyStimulus(3'b000, 96'd0);
        #1;
        checkOutput("wd_issue_tdata", m_tdata, 32'h1111_00EE);
        m_tready = 1'b1;
        @(negedge clk);
        m_tready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("wd_err_early", 32'(wdog_err), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("wd_err_set", 32'(wdog_err), 32'd1);
        checkOutput("wd_frame_cnt", 32'(frame_cnt), 32'd11);
        checkOutput("wd_src_sel", 32'(src_sel), 32'd2);
        repeat (7) @(negedge clk);
        #1;
        checkOutput("wd_gap_end_src_sel", 32'(src_sel), 32'd2);
        w = '{3'b001, {32'h2222_000C, 32'h1111_000C, 32'h0000_000C}, 3'b001, 32'h0000_000C, 16'd12, 5, 0};
        runFrame(w);
        checkOutput("wd_err_sticky", 32'(wdog_err), 32'd1);

        // Reset asserted mid-frame while the master is busy.
        @(negedge clk);
        applyStimulus(3'b100, {32'h2222_00DD, 32'h1111_00DD, 32'h0000_00DD});
        #1;
        checkOutput("rm_grant", 32'(s_tready), 32'd4);
        @(negedge clk);
        applyStimulus(3'b000, 96'd0);
        m_tready = 1'b1;
        @(negedge clk);
        m_tready = 1'b0;
        busy     = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("rm_tvalid", 32'(m_tvalid), 32'd0);
        checkOutput("rm_tdata", m_tdata, 32'd0);
        checkOutput("rm_src_sel", 32'(src_sel), 32'd0);
        checkOutput("rm_active", 32'(active), 32'd0);
        checkOutput("rm_frame_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("rm_wdog_err", 32'(wdog_err), 32'd0);
        checkOutput("rm_tready", 32'(s_tready), 32'd0);
        @(negedge clk);
        busy   = 1'b0;
        resetn = 1'b1;
        w = '{3'b111, {32'h2222_00F0, 32'h1111_00F0, 32'h0000_00F0}, 3'b001, 32'h0000_00F0, 16'd1, 2, 0};
        runFrame(w);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
